// File: rtl/decode_queue_pkg.sv
// Shared decode definitions: packed decoded-packet layout, instruction-format
// one-hot codes and functional-unit identifiers used by the decode queue.
package decode_queue_pkg;

    // Field widths of the packed decoded packet (bit 0 holds instFormat[0]).
    localparam int unsigned INST_FORMAT_W = 25;
    localparam int unsigned OPCODE_W      = 12;
    localparam int unsigned ADDRESS_W     = 64;
    localparam int unsigned FUNC_UNIT_W   = 3;
    localparam int unsigned MAJ_ID_W      = 64;
    localparam int unsigned MIN_ID_W      = 7;
    localparam int unsigned IS_64BIT_W    = 1;
    localparam int unsigned PID_W         = 20;
    localparam int unsigned TID_W         = 16;
    localparam int unsigned OP_RW_W       = 8;
    localparam int unsigned OP_IS_REG_W   = 4;
    localparam int unsigned BODY_W        = 84;

    // Field offsets, each field packed directly above the previous one.
    localparam int unsigned INST_FORMAT_LSB = 0;
    localparam int unsigned OPCODE_LSB      = INST_FORMAT_LSB + INST_FORMAT_W;
    localparam int unsigned ADDRESS_LSB     = OPCODE_LSB + OPCODE_W;
    localparam int unsigned FUNC_UNIT_LSB   = ADDRESS_LSB + ADDRESS_W;
    localparam int unsigned MAJ_ID_LSB      = FUNC_UNIT_LSB + FUNC_UNIT_W;
    localparam int unsigned MIN_ID_LSB      = MAJ_ID_LSB + MAJ_ID_W;
    localparam int unsigned IS_64BIT_LSB    = MIN_ID_LSB + MIN_ID_W;
    localparam int unsigned PID_LSB         = IS_64BIT_LSB + IS_64BIT_W;
    localparam int unsigned TID_LSB         = PID_LSB + PID_W;
    localparam int unsigned OP_RW_LSB       = TID_LSB + TID_W;
    localparam int unsigned OP_IS_REG_LSB   = OP_RW_LSB + OP_RW_W;
    localparam int unsigned BODY_LSB        = OP_IS_REG_LSB + OP_IS_REG_W;
    localparam int unsigned ENTRY_W         = BODY_LSB + BODY_W;

    // Instruction-format one-hot codes carried in instFormat.
    localparam logic [INST_FORMAT_W-1:0] FMT_I   = 25'(1) << 0;
    localparam logic [INST_FORMAT_W-1:0] FMT_B   = 25'(1) << 1;
    localparam logic [INST_FORMAT_W-1:0] FMT_SC  = 25'(1) << 2;
    localparam logic [INST_FORMAT_W-1:0] FMT_D   = 25'(1) << 3;
    localparam logic [INST_FORMAT_W-1:0] FMT_DS  = 25'(1) << 4;
    localparam logic [INST_FORMAT_W-1:0] FMT_DQ  = 25'(1) << 5;
    localparam logic [INST_FORMAT_W-1:0] FMT_DX  = 25'(1) << 6;
    localparam logic [INST_FORMAT_W-1:0] FMT_X   = 25'(1) << 7;
    localparam logic [INST_FORMAT_W-1:0] FMT_XL  = 25'(1) << 8;
    localparam logic [INST_FORMAT_W-1:0] FMT_XFX = 25'(1) << 9;
    localparam logic [INST_FORMAT_W-1:0] FMT_XFL = 25'(1) << 10;
    localparam logic [INST_FORMAT_W-1:0] FMT_XS  = 25'(1) << 11;
    localparam logic [INST_FORMAT_W-1:0] FMT_XO  = 25'(1) << 12;
    localparam logic [INST_FORMAT_W-1:0] FMT_A   = 25'(1) << 13;
    localparam logic [INST_FORMAT_W-1:0] FMT_M   = 25'(1) << 14;
    localparam logic [INST_FORMAT_W-1:0] FMT_MD  = 25'(1) << 15;
    localparam logic [INST_FORMAT_W-1:0] FMT_MDS = 25'(1) << 16;
    localparam logic [INST_FORMAT_W-1:0] FMT_VA  = 25'(1) << 17;
    localparam logic [INST_FORMAT_W-1:0] FMT_VC  = 25'(1) << 18;
    localparam logic [INST_FORMAT_W-1:0] FMT_VX  = 25'(1) << 19;
    localparam logic [INST_FORMAT_W-1:0] FMT_XX1 = 25'(1) << 20;
    localparam logic [INST_FORMAT_W-1:0] FMT_XX2 = 25'(1) << 21;
    localparam logic [INST_FORMAT_W-1:0] FMT_XX3 = 25'(1) << 22;

    // Functional-unit identifiers carried in funcUnitType (5 is unassigned).
    typedef enum logic [FUNC_UNIT_W-1:0] {
        FU_FX     = 3'd0,
        FU_FP     = 3'd1,
        FU_VX     = 3'd2,
        FU_CR     = 3'd3,
        FU_LS     = 3'd4,
        FU_BRANCH = 3'd6
    } func_unit_e;

    // Structured view of the packed entry; first member is the most significant.
    typedef struct packed {
        logic [BODY_W-1:0]        body;
        logic [OP_IS_REG_W-1:0]   op_is_reg;
        logic [OP_RW_W-1:0]       op_rw;
        logic [TID_W-1:0]         tid;
        logic [PID_W-1:0]         pid;
        logic                     is_64bit;
        logic [MIN_ID_W-1:0]      min_id;
        logic [MAJ_ID_W-1:0]      maj_id;
        logic [FUNC_UNIT_W-1:0]   func_unit_type;
        logic [ADDRESS_W-1:0]     address;
        logic [OPCODE_W-1:0]      opcode;
        logic [INST_FORMAT_W-1:0] inst_format;
    } decoded_pkt_t;

    // Extract the major instruction ID from a packed entry.
    function automatic logic [MAJ_ID_W-1:0] pkt_maj_id(input logic [ENTRY_W-1:0] pkt);
        decoded_pkt_t view;
        view = decoded_pkt_t'(pkt);
        return view.maj_id;
    endfunction

endpackage

// File: rtl/decode_queue_ram.sv
// Entry storage for the decode queue: one synchronous write port and one
// asynchronous read port so the head entry is presented with zero latency.
module decode_queue_ram
    import decode_queue_pkg::*;
#(
    parameter int unsigned depth      = 8,
    parameter int unsigned entryWidth = ENTRY_W,
    parameter int unsigned ptrWidth   = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ptrWidth-1:0]   wr_addr,
    input  logic [entryWidth-1:0] wr_data,
    input  logic [ptrWidth-1:0]   rd_addr,
    output logic [entryWidth-1:0] rd_data
);

    // Storage is intentionally never cleared; consumers qualify it with valid.
    logic [entryWidth-1:0] mem_reg [depth];

    // Write the incoming packet into the addressed slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // Show-ahead read straight from the registered read pointer.
    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/decode_queue.sv
// Decoded-instruction queue between the decode mux and issue/dispatch.
// Circular buffer with show-ahead output, early registered stall with skid
// slots, sticky overflow and branch-redirect flush.
// Optional statistics (peak occupancy, accepted-push counter) are built when
// the macro DECODE_QUEUE_STATS_EN is defined.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned depth               = 8,
    parameter int unsigned entryWidth          = ENTRY_W,
    parameter int unsigned skidSlots           = 2,
    parameter int unsigned ptrWidth            = $clog2(depth),
    parameter int          DecodeQueueInstance = 0
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  enable_i,
    input  logic [entryWidth-1:0] entry_i,
    output logic                  stall_o,
    output logic                  valid_o,
    output logic [entryWidth-1:0] entry_o,
    input  logic                  ready_i,
    output logic [ptrWidth:0]     count_o,
    output logic                  overflow_o
`ifdef DECODE_QUEUE_STATS_EN
    ,
    output logic [ptrWidth:0]     peakCount_o,
    output logic [31:0]           pushCount_o
`endif
);

    // Reject configurations the pointer arithmetic cannot support.
    if (depth < 4 || (depth & (depth - 1)) != 0 || skidSlots >= depth
        || DecodeQueueInstance < 0) begin : g_bad_config
        $error("decode_queue: invalid depth/skidSlots/instance configuration");
    end

    localparam logic [ptrWidth:0]   COUNT_DEPTH = (ptrWidth + 1)'(depth);
    localparam logic [ptrWidth:0]   STALL_LEVEL = (ptrWidth + 1)'(depth - skidSlots);
    localparam logic [ptrWidth:0]   COUNT_ONE   = (ptrWidth + 1)'(1);
    localparam logic [ptrWidth-1:0] PTR_ONE     = ptrWidth'(1);

    logic [ptrWidth-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ptrWidth-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ptrWidth:0]   count_reg, count_next;
    logic                stall_reg, stall_next;
    logic                overflow_reg, overflow_next;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic wr_en;

    assign full  = (count_reg == COUNT_DEPTH);
    assign empty = (count_reg == '0);
    // ready_i is only meaningful while an entry is being presented.
    assign pop   = !empty && ready_i;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push  = enable_i && (!full || pop);
    // Flush and reset both discard a coincident push.
    assign wr_en = push && !flush_i && !reset_i;

    decode_queue_ram #(
        .depth      (depth),
        .entryWidth (entryWidth),
        .ptrWidth   (ptrWidth)
    ) u_ram (
        .clk     (clock_i),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg),
        .wr_data (entry_i),
        .rd_addr (rd_ptr_reg),
        .rd_data (entry_o)
    );

    // Next-state for pointers, occupancy, stall and overflow; flush wins.
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        stall_next    = stall_reg;
        overflow_next = overflow_reg;

        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            stall_next  = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_next = count_reg + COUNT_ONE;
                2'b01:   count_next = count_reg - COUNT_ONE;
                default: count_next = count_reg;
            endcase
            // Stall looks at the post-update occupancy so the skid slots can
            // still absorb packets already in flight from the front end.
            stall_next = (count_next >= STALL_LEVEL);
            if (enable_i && full && !pop) begin
                overflow_next = 1'b1;
            end
        end
    end

    // Control state registers with synchronous reset (reset beats flush).
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            stall_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            stall_reg    <= stall_next;
            overflow_reg <= overflow_next;
        end
    end

    assign valid_o    = !empty;
    assign count_o    = count_reg;
    assign stall_o    = stall_reg;
    assign overflow_o = overflow_reg;

`ifdef DECODE_QUEUE_STATS_EN
    logic [ptrWidth:0] peak_reg;
    logic [31:0]       push_cnt_reg;

    // High-water mark trails count by one cycle; push counter survives flush.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            peak_reg     <= '0;
            push_cnt_reg <= '0;
        end else begin
            if (count_reg > peak_reg) begin
                peak_reg <= count_reg;
            end
            if (wr_en) begin
                push_cnt_reg <= push_cnt_reg + 32'd1;
            end
        end
    end

    assign peakCount_o = peak_reg;
    assign pushCount_o = push_cnt_reg;
`else
    // Statistics registers and ports are not built in this configuration.
`endif

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Decoded-instruction buffer directly downstream of the decode mux stage; registers each `enable`-qualified decoded packet into a circular queue.
- Presents packets in order to the issue/dispatch stage through a valid/ready handshake.
- The decode mux has no stall input, so the queue raises an early stall to the front end.
- Absorbs in-flight packets in reserved skid slots and flushes on branch redirect.

Parameters:
- `depth`, 8, number of entries; power of two, at least 4.
- `entryWidth`, 308, packed decoded-packet width (layout in package).
- `skidSlots`, 2, entries reserved for packets already in flight when `stall_o` rises.
- `ptrWidth`, `$clog2(depth)`, pointer width.
- `DecodeQueueInstance`, 0, instance number for multi-decoder builds.

Ports:
- `clock_i`  in  1  clock
- `reset_i`  in  1  synchronous, active-high reset
- `flush_i`  in  1  discard all entries (branch redirect)
- `enable_i`  in  1  decode mux `enable_o`; push request
- `entry_i`  in  `entryWidth`  packed packet, bit 0 first: `instFormat[25]`, `opcode[12]`, `address[64]`, `funcUnitType[3]`, `majID[64]`, `minID[7]`, `is64Bit[1]`, `pid[20]`, `tid[16]`, `op1..4rw[8]`, `op1..4IsReg[4]`, `body[84]`
- `stall_o`  out  1  front end must stop issuing new fetches into decode
- `valid_o`  out  1  head entry valid
- `entry_o`  out  `entryWidth`  head entry
- `ready_i`  in  1  downstream accepts head this cycle
- `count_o`  out  `ptrWidth`+1  occupancy
- `overflow_o`  out  1  sticky: push arrived while full
- `peakCount_o`  out  `ptrWidth`+1  high-water mark (only with feature)
- `pushCount_o`  out  32  accepted pushes, wrapping (only with feature)

Behaviour:
- Reset: on `reset_i` high at a clock edge, clear `wrPtr`, `rdPtr`, `count`, `stall_o`, `overflow_o` and stats to 0.
  - `valid_o` = 0 after reset.
  - Storage array is not cleared; `entry_o` is don't-care while `valid_o` = 0.
- Definitions:
  - `push = enable_i && (!full || pop)`
  - `pop = valid_o && ready_i`
  - `full = (count == depth)`
  - `empty = (count == 0)`
- Show-ahead read:
  - `valid_o = !empty`; `entry_o = mem[rdPtr]`, combinational from the registered pointer.
  - Zero-cycle read latency once an entry is written.
  - Write-to-`valid_o` latency is 1 cycle; an entry pushed at edge N is visible after edge N.
- Push: write `mem[wrPtr] <= entry_i`; `wrPtr` increments modulo `depth` (natural wrap, power of two).
- Pop: `rdPtr` increments modulo `depth`.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - Full: both accepted, count stays `depth`.
  - Empty: no pop is possible since `valid_o` = 0; the push lands and count becomes 1. No bypass.
- Overflow: `enable_i` while full with no pop drops the packet and sets `overflow_o`, which stays set until reset.
- Stall (registered): `stall_o <= (next_count >= depth - skidSlots)`, using the post-update count.
- Flush:
  - `flush_i` has priority over push and pop in the same cycle.
  - Pointers and count go to 0; `stall_o` goes to 0 next cycle; `overflow_o` is untouched.
  - A push coinciding with the flush is discarded.
- Reset priority: reset beats flush. Reset in the middle of a stream discards everything; the first push afterwards lands at index 0.
- `ready_i` while `valid_o` = 0 is ignored.

Optional Feature:
- Macro: `DECODE_QUEUE_STATS_EN`.
- Defined:
  - `peakCount_o` holds max(`count`) since reset and updates one cycle after `count` changes.
  - `pushCount_o` increments on each accepted push, wraps at 2^32 and is cleared by reset; flush does not clear it.
- Undefined: both ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Shared decode package holds:
  - field width constants and offsets of the packed entry;
  - format one-hot constants (I=2^0 … XX3=2^22);
  - functional-unit IDs (FX=0, FP=1, VX=2, CR=3, LS=4, Branch=6).
- Natural sub-module: `decode_queue_ram`, a depth×`entryWidth` array with one write port and one async read port.
- Pointer, count, stall and flush control stay in the top.

Test Plan:
- Reset, then push 3 packets with majID 1, 2, 3 with `ready_i` = 0. Required: `count_o` = 3, `valid_o` = 1, `entry_o.majID` = 1. Raise `ready_i` for 3 cycles: outputs majID 1, 2, 3 in order, then `valid_o` = 0.
- `depth` = 8, `skidSlots` = 2, push continuously with `ready_i` = 0. Required: `stall_o` = 1 the cycle after `count` reaches 6. Pushes 7 and 8 are accepted; push 9 is dropped with `overflow_o` = 1 and `count_o` = 8.
- Full queue, push and pop in the same cycle. Required: `count_o` stays 8 and the new entry appears after 7 further pops.
- Wrap-around: 20 push/pop pairs with majID 0..19. Required: in-order output and `count_o` ≤ 1 throughout.
- `flush_i` with 5 entries plus a simultaneous push. Required: next cycle `count_o` = 0, `valid_o` = 0, `stall_o` = 0, `overflow_o` unchanged.
- With `DECODE_QUEUE_STATS_EN`: 10 pushes with interleaved pops to a maximum occupancy of 4. Required: `peakCount_o` = 4, `pushCount_o` = 10; both read 0 after reset.
